// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and widths for the memory bus arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_sel_t;

    localparam int STARVE_W = 4;
    localparam int WDOG_W   = 8;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - counts busy cycles and flags the cycle a transaction times out
module bus_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The counter holds the number of busy cycles already spent, so the
    // TIMEOUT_CYCLES-th busy cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] cnt;

    // Restart on every grant, otherwise advance once per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between fetch and data ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_ena,
    output logic [31:0] imem_din,
    output logic        imem_ready,
    output logic        imem_err,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_dout,
    input  logic        dmem_ena,
    input  logic [3:0]  dmem_wen,
    output logic [31:0] dmem_din,
    output logic        dmem_ready,
    output logic        dmem_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  expired;
    logic                  grant;
    port_sel_t             grant_port;

    logic busy;
    logic done;
    logic timed_out;
    logic i_done;
    logic d_done;
    logic i_elig;
    logic d_elig;
    logic arb_run;

    assign busy      = (state != IDLE);
    assign done      = busy && (bus_ack || expired);
    assign timed_out = busy && expired && !bus_ack;
    assign i_done    = (state == BUSY_I) && done;
    assign d_done    = (state == BUSY_D) && done;
    assign arb_run   = (state == IDLE) || done;

    // A port finishing now, or still showing its ready pulse, cannot be
    // granted again until its requester has had a chance to re-issue.
    assign i_elig = imem_ena && !i_done && !imem_ready;
    assign d_elig = dmem_ena && !d_done && !dmem_ready;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (grant),
        .enable  (busy),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: follow a grant, otherwise drop to IDLE once the owner finishes.
    always_comb begin
        next_state = state;
        if (grant) begin
            next_state = (grant_port == PORT_D) ? BUSY_D : BUSY_I;
        end else if (done) begin
            next_state = IDLE;
        end
    end

    // Arbitration: data first, fetch once it has waited STARVE_LIMIT data grants.
    always_comb begin
        grant      = 1'b0;
        grant_port = PORT_D;
        if (arb_run) begin
            if (d_elig && (!i_elig || starve_cnt != STARVE_MAX)) begin
                grant      = 1'b1;
                grant_port = PORT_D;
            end else if (i_elig) begin
                grant      = 1'b1;
                grant_port = PORT_I;
            end
        end
    end

    // Count data grants that overtake a waiting fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!imem_ena || (grant && grant_port == PORT_I)) begin
            starve_cnt <= '0;
        end else if (grant && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Bus-side registers, loaded from the winner at each grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wen   <= '0;
        end else begin
            bus_req <= (next_state != IDLE);
            if (grant && grant_port == PORT_D) begin
                bus_addr  <= dmem_addr;
                bus_wdata <= dmem_dout;
                bus_wen   <= dmem_wen;
            end else if (grant) begin
                bus_addr  <= imem_addr;
                bus_wdata <= '0;
                bus_wen   <= '0;
            end
        end
    end

    // Requester-side completion: ready pulse, error flag and returned data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_ready <= 1'b0;
            imem_err   <= 1'b0;
            imem_din   <= '0;
            dmem_ready <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_din   <= '0;
        end else begin
            imem_ready <= i_done;
            imem_err   <= i_done && timed_out;
            dmem_ready <= d_done;
            dmem_err   <= d_done && timed_out;
            if (i_done) begin
                imem_din <= timed_out ? '0 : bus_rdata;
            end
            if (d_done && timed_out) begin
                dmem_din <= '0;
            end else if (d_done && bus_wen == '0) begin
                dmem_din <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TO     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_ena;
    logic [31:0] imem_din;
    logic        imem_ready;
    logic        imem_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dout;
    logic        dmem_ena;
    logic [3:0]  dmem_wen;
    logic [31:0] dmem_din;
    logic        dmem_ready;
    logic        dmem_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_tests = 0;
    int n_fail  = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT   (STARVE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_ena   (imem_ena),
        .imem_din   (imem_din),
        .imem_ready (imem_ready),
        .imem_err   (imem_err),
        .dmem_addr  (dmem_addr),
        .dmem_dout  (dmem_dout),
        .dmem_ena   (dmem_ena),
        .dmem_wen   (dmem_wen),
        .dmem_din   (dmem_din),
        .dmem_ready (dmem_ready),
        .dmem_err   (dmem_err),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wen    (bus_wen),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one transaction in flight (owner 0=none, 1=fetch,
    // 2=data) with its age in busy cycles; expected outputs follow the rules.
    int          m_owner;
    int          m_age;
    int          m_starve;
    int          m_pick;
    logic        m_fin;
    logic        m_tmo;
    logic        m_wi;
    logic        m_wd;
    int          grants[$];
    logic        e_bus_req;
    logic [31:0] e_bus_addr;
    logic [31:0] e_bus_wdata;
    logic [3:0]  e_bus_wen;
    logic        e_i_ready;
    logic        e_i_err;
    logic [31:0] e_i_din;
    logic        e_d_ready;
    logic        e_d_err;
    logic [31:0] e_d_din;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = 0; m_age = 0; m_starve = 0;
            e_bus_req = 0; e_bus_addr = 0; e_bus_wdata = 0; e_bus_wen = 0;
            e_i_ready = 0; e_i_err = 0; e_i_din = 0;
            e_d_ready = 0; e_d_err = 0; e_d_din = 0;
        end else begin
            m_fin = (m_owner != 0) && (bus_ack || (m_age + 1 == TO));
            m_tmo = m_fin && !bus_ack;
            m_wi  = imem_ena && !(m_fin && m_owner == 1) && !e_i_ready;
            m_wd  = dmem_ena && !(m_fin && m_owner == 2) && !e_d_ready;
            e_i_ready = 0; e_i_err = 0; e_d_ready = 0; e_d_err = 0;
            if (m_fin && m_owner == 1) begin
                e_i_ready = 1;
                e_i_err   = m_tmo;
                e_i_din   = m_tmo ? 32'h0 : bus_rdata;
            end
            if (m_fin && m_owner == 2) begin
                e_d_ready = 1;
                e_d_err   = m_tmo;
                if (m_tmo) e_d_din = 32'h0;
                else if (e_bus_wen == 4'h0) e_d_din = bus_rdata;
            end
            m_pick = 0;
            if (m_owner == 0 || m_fin) begin
                if (m_wi && m_wd) m_pick = (m_starve == STARVE) ? 1 : 2;
                else if (m_wd) m_pick = 2;
                else if (m_wi) m_pick = 1;
            end
            if (!imem_ena || m_pick == 1) m_starve = 0;
            else if (m_pick == 2 && m_starve < STARVE) m_starve++;
            if (m_pick == 1) begin
                m_owner = 1; m_age = 0;
                e_bus_addr = imem_addr; e_bus_wdata = 0; e_bus_wen = 0;
                grants.push_back(1);
            end else if (m_pick == 2) begin
                m_owner = 2; m_age = 0;
                e_bus_addr = dmem_addr; e_bus_wdata = dmem_dout; e_bus_wen = dmem_wen;
                grants.push_back(2);
            end else if (m_fin) begin
                m_owner = 0;
            end else if (m_owner != 0) begin
                m_age++;
            end
            e_bus_req = (m_owner != 0);
        end
    end

    // Compare every output against the model each cycle out of reset.
    always @(negedge clk) begin
        if (started && reset === 1'b1) begin
            chk("bus_req",    {31'b0, bus_req},    {31'b0, e_bus_req});
            chk("bus_addr",   bus_addr,            e_bus_addr);
            chk("bus_wdata",  bus_wdata,           e_bus_wdata);
            chk("bus_wen",    {28'b0, bus_wen},    {28'b0, e_bus_wen});
            chk("imem_ready", {31'b0, imem_ready}, {31'b0, e_i_ready});
            chk("imem_err",   {31'b0, imem_err},   {31'b0, e_i_err});
            chk("imem_din",   imem_din,            e_i_din);
            chk("dmem_ready", {31'b0, dmem_ready}, {31'b0, e_d_ready});
            chk("dmem_err",   {31'b0, dmem_err},   {31'b0, e_d_err});
            chk("dmem_din",   dmem_din,            e_d_din);
            chk("ready_excl", {31'b0, imem_ready & dmem_ready}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        int nd;
        int ni;
        reset = 1'b0;
        imem_addr = 0; imem_ena = 0;
        dmem_addr = 0; dmem_dout = 0; dmem_ena = 0; dmem_wen = 0;
        bus_rdata = 0; bus_ack = 0;
        nxt(); nxt();
        chk("rst_bus_req",    {31'b0, bus_req},    32'h0);
        chk("rst_bus_addr",   bus_addr,            32'h0);
        chk("rst_dmem_ready", {31'b0, dmem_ready}, 32'h0);
        chk("rst_imem_din",   imem_din,            32'h0);
        reset = 1'b1;
        started = 1'b1;
        nxt();

        // Single load: ack in cycle 3, ready in cycle 4.
        dmem_addr = 32'h100; dmem_wen = 4'h0; dmem_ena = 1;           // cycle 0
        nxt(); chk("t1_req_c1", {31'b0, bus_req}, 32'h1);             // cycle 1
        chk("t1_addr", bus_addr, 32'h100);
        nxt();                                                        // cycle 2
        nxt(); bus_ack = 1; bus_rdata = 32'hDEADBEEF;                 // cycle 3
        chk("t1_no_ready_c3", {31'b0, dmem_ready}, 32'h0);
        nxt(); bus_ack = 0;                                           // cycle 4
        chk("t1_ready_c4", {31'b0, dmem_ready}, 32'h1);
        chk("t1_din", dmem_din, 32'hDEADBEEF);
        chk("t1_err", {31'b0, dmem_err}, 32'h0);
        dmem_ena = 0;
        nxt(); chk("t1_idle", {31'b0, bus_req}, 32'h0);

        // Simultaneous requests: data first, fetch granted in the data ack cycle.
        imem_addr = 32'h200; imem_ena = 1; dmem_addr = 32'h300; dmem_ena = 1;  // cycle 0
        nxt(); chk("t2_first_addr", bus_addr, 32'h300);                        // cycle 1
        bus_ack = 1; bus_rdata = 32'hAAAA0001;
        nxt(); chk("t2_d_ready", {31'b0, dmem_ready}, 32'h1);                  // cycle 2
        chk("t2_d_din", dmem_din, 32'hAAAA0001);
        chk("t2_second_addr", bus_addr, 32'h200);
        chk("t2_req_held", {31'b0, bus_req}, 32'h1);
        dmem_ena = 0; bus_rdata = 32'hBBBB0002;
        nxt(); chk("t2_i_ready", {31'b0, imem_ready}, 32'h1);                  // cycle 3
        chk("t2_i_din", imem_din, 32'hBBBB0002);
        imem_ena = 0; bus_ack = 0;
        nxt(); chk("t2_idle", {31'b0, bus_req}, 32'h0);

        // Both ports re-requesting continuously: the completing data port is
        // masked in its ack cycle, so the waiting fetch takes the next grant.
        grants.delete();
        nd = 0; ni = 0;
        for (int i = 0; i < 24; i++) begin
            bus_ack = bus_req;
            bus_rdata = 32'h5000 + i;
            if (dmem_ready) dmem_ena = 0;
            else if (!dmem_ena && nd < 4) begin
                dmem_addr = 32'h1000 + 4 * nd; dmem_wen = 0; dmem_ena = 1; nd++;
            end
            if (imem_ready) imem_ena = 0;
            else if (!imem_ena && ni < 3) begin
                imem_addr = 32'h2000 + 4 * ni; imem_ena = 1; ni++;
            end
            nxt();
        end
        bus_ack = 0;
        chk("t3_grant_count", grants.size(), 32'd7);
        if (grants.size() >= 4) begin
            chk("t3_g0", grants[0], 32'd2);
            chk("t3_g1", grants[1], 32'd1);
            chk("t3_g2", grants[2], 32'd2);
            chk("t3_g3", grants[3], 32'd1);
        end
        nxt();

        // Load timeout: no ack, ready with err 9 cycles after the grant decision.
        dmem_addr = 32'h500; dmem_wen = 0; dmem_ena = 1;               // cycle 0
        repeat (8) nxt();                                              // cycle 8
        chk("t4_no_ready_c8", {31'b0, dmem_ready}, 32'h0);
        chk("t4_req_c8", {31'b0, bus_req}, 32'h1);
        nxt();                                                         // cycle 9
        chk("t4_ready_c9", {31'b0, dmem_ready}, 32'h1);
        chk("t4_err", {31'b0, dmem_err}, 32'h1);
        chk("t4_din_zero", dmem_din, 32'h0);
        chk("t4_req_drop", {31'b0, bus_req}, 32'h0);
        dmem_ena = 0;
        nxt();

        // Ack in the timeout cycle wins.
        dmem_addr = 32'h504; dmem_ena = 1;                             // cycle 0
        repeat (8) nxt(); bus_ack = 1; bus_rdata = 32'hCAFEF00D;       // cycle 8
        nxt(); bus_ack = 0;                                            // cycle 9
        chk("t4b_ready", {31'b0, dmem_ready}, 32'h1);
        chk("t4b_err", {31'b0, dmem_err}, 32'h0);
        chk("t4b_din", dmem_din, 32'hCAFEF00D);
        dmem_ena = 0;
        nxt();

        // Fetch timeout.
        imem_addr = 32'h700; imem_ena = 1;
        repeat (9) nxt();
        chk("t4c_i_ready", {31'b0, imem_ready}, 32'h1);
        chk("t4c_i_err", {31'b0, imem_err}, 32'h1);
        chk("t4c_i_din", imem_din, 32'h0);
        imem_ena = 0;
        nxt();

        // Store: bus gets enables and data, dmem_din is left alone.
        dmem_addr = 32'h600; dmem_wen = 4'b0011; dmem_dout = 32'h12345678; dmem_ena = 1;
        nxt(); chk("t5_wen", {28'b0, bus_wen}, 32'h3);
        chk("t5_wdata", bus_wdata, 32'h12345678);
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        nxt(); bus_ack = 0;
        chk("t5_ready", {31'b0, dmem_ready}, 32'h1);
        chk("t5_din_kept", dmem_din, 32'hCAFEF00D);
        dmem_ena = 0; dmem_wen = 0; dmem_dout = 0;
        nxt();

        // Reset mid-transaction.
        dmem_addr = 32'h800; dmem_ena = 1;
        nxt(); chk("t6_req", {31'b0, bus_req}, 32'h1);
        nxt(); reset = 1'b0;
        #1 chk("t6_req_async", {31'b0, bus_req}, 32'h0);
        nxt(); chk("t6_no_ready", {31'b0, dmem_ready}, 32'h0);
        dmem_ena = 0; reset = 1'b1;
        nxt();
        dmem_addr = 32'h900; dmem_ena = 1;
        nxt(); chk("t6_new_addr", bus_addr, 32'h900);
        bus_ack = 1; bus_rdata = 32'h13572468;
        nxt(); bus_ack = 0;
        chk("t6_ready", {31'b0, dmem_ready}, 32'h1);
        chk("t6_din", dmem_din, 32'h13572468);
        dmem_ena = 0;
        nxt(); nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
